mem_arbiter: RTL and testbench

- Sole owner of the byte-wide RAM port; shares it between instruction fetch (IF, read-only, fixed-length) and the load/store buffer (LSB, byte/half/word loads and stores).
- Sequences each multi-byte transaction as a stream of single-byte RAM accesses and assembles the load data.
- Handles IO-buffer back-pressure and rollback.
- Sits between the fetcher/LSB and the top-level RAM wrapper.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory arbiter.
//   ma_state_e : arbiter states (idle, IF read, LSB read, LSB write)
//   grant_e    : last-granted requester, used for round-robin on ties
//   MA_IO_SEL  : addr[17:16] value selecting the memory-mapped IO region
//   CNT_W      : byte counter width, wide enough for a 64-byte fetch
package mem_arbiter_pkg;

  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;
  localparam logic LOAD_MEM  = 1'b0;
  localparam logic WRITE_MEM = 1'b1;

  localparam logic [1:0] MA_IO_SEL = 2'b11;
  localparam int unsigned CNT_W    = 7;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_IF_RD  = 2'd1,
    MA_LSB_RD = 2'd2,
    MA_LSB_WR = 2'd3
  } ma_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_LSB = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the load/store
// buffer. Multi-byte accesses are issued as one RAM byte per cycle; read
// bytes are assembled little-endian.
//   clk, rst             : clock, asynchronous active-high reset
//   rdy                  : global enable, low freezes all state
//   rollback_signal      : flush; aborts reads, stores still complete
//   if_req/if_addr       : fetch request of IF_BYTES bytes
//   if_done/if_data      : fetch completion pulse and data
//   lsb_req/lsb_wr/lsb_len/lsb_addr/lsb_wdata : LSB load/store request
//   lsb_done/lsb_rdata   : LSB completion pulse and zero-extended load data
//   mem_din/mem_dout/mem_a/mem_wr : RAM byte port (1-cycle read latency)
//   io_buffer_full       : stalls writes into the IO region
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned IF_BYTES = 4,
  parameter logic [1:0]  IO_SEL   = MA_IO_SEL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback_signal,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [8*IF_BYTES-1:0]   if_data,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [2:0]              lsb_len,
  input  logic [31:0]             lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  ma_state_e             state_q;
  grant_e                last_grant_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [31:0]           base_q;
  logic [2:0]            len_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem_a_q;
  logic [7:0]            mem_dout_q;
  logic                  mem_wr_q;
  logic                  if_done_q;
  logic                  lsb_done_q;
  logic [8*IF_BYTES-1:0] if_data_q;
  logic [31:0]           lsb_rdata_q;

  logic [CNT_W-1:0]      cnt_d;
  logic [31:0]           addr_d;
  logic [CNT_W-1:0]      n_rd;
  logic                  grant_any;
  logic                  grant_lsb;
  logic                  wr_stall;

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    addr_d    = base_q + 32'(cnt_d);
    n_rd      = (state_q == MA_IF_RD) ? CNT_W'(IF_BYTES) : CNT_W'(len_q);
    wr_stall  = (state_q == MA_LSB_WR) && (mem_a_q[17:16] == IO_SEL) && io_buffer_full;
    // No grant while a done pulse is out: the requester still holds req
    // during that cycle and only drops it one cycle later.
    grant_any = (if_req || lsb_req) && !rollback_signal && !if_done_q && !lsb_done_q;
    if (if_req && lsb_req) grant_lsb = (last_grant_q == GRANT_IF);
    else                   grant_lsb = lsb_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MA_IDLE;
      last_grant_q <= GRANT_IF;
      cnt_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      wdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= LOAD_MEM;
      if_done_q    <= FALSE;
      lsb_done_q   <= FALSE;
      if_data_q    <= '0;
      lsb_rdata_q  <= '0;
    end else if (rdy) begin
      if_done_q  <= FALSE;
      lsb_done_q <= FALSE;
      unique case (state_q)
        MA_IDLE: begin
          if (grant_any) begin
            cnt_q <= '0;
            if (grant_lsb) begin
              last_grant_q <= GRANT_LSB;
              base_q       <= lsb_addr;
              len_q        <= lsb_len;
              mem_a_q      <= lsb_addr;
              if (lsb_wr) begin
                state_q    <= MA_LSB_WR;
                mem_wr_q   <= WRITE_MEM;
                mem_dout_q <= lsb_wdata[7:0];
                // Remaining store bytes are kept pre-shifted so the next
                // byte to drive is always wdata_q[7:0].
                wdata_q    <= lsb_wdata >> 8;
              end else begin
                state_q     <= MA_LSB_RD;
                lsb_rdata_q <= '0;
              end
            end else begin
              last_grant_q <= GRANT_IF;
              base_q       <= if_addr;
              mem_a_q      <= if_addr;
              state_q      <= MA_IF_RD;
            end
          end
        end

        MA_IF_RD, MA_LSB_RD: begin
          if (rollback_signal) begin
            state_q <= MA_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d < n_rd) mem_a_q <= addr_d;
            // mem_din holds the byte addressed one cycle earlier.
            if (state_q == MA_IF_RD) begin
              for (int unsigned i = 0; i < IF_BYTES; i++)
                if (cnt_q == CNT_W'(i + 1)) if_data_q[8*i +: 8] <= mem_din;
            end else begin
              for (int unsigned i = 0; i < 4; i++)
                if (cnt_q == CNT_W'(i + 1)) lsb_rdata_q[8*i +: 8] <= mem_din;
            end
            if (cnt_q == n_rd) begin
              state_q <= MA_IDLE;
              if (state_q == MA_IF_RD) if_done_q  <= TRUE;
              else                     lsb_done_q <= TRUE;
            end
          end
        end

        MA_LSB_WR: begin
          if (!wr_stall) begin
            if (cnt_d < CNT_W'(len_q)) begin
              cnt_q      <= cnt_d;
              mem_a_q    <= addr_d;
              mem_dout_q <= wdata_q[7:0];
              wdata_q    <= wdata_q >> 8;
            end else begin
              mem_wr_q   <= LOAD_MEM;
              lsb_done_q <= TRUE;
              state_q    <= MA_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign mem_wr    = mem_wr_q & rdy & ~wr_stall;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte RAM model whose unwritten
// locations read back 11 22 33 44 repeating by addr[1:0].
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback_signal;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [2:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ram   [0:4095];
  bit          wflag [0:4095];
  int unsigned wr_count  = 0;
  int unsigned if_pulses = 0;

  mem_arbiter #(.IF_BYTES(4), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] idx(input logic [31:0] a);
    return {a[17:16], a[9:0]};
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    logic [7:0] k;
    k = {6'b0, a[1:0]} + 8'd1;
    return wflag[idx(a)] ? ram[idx(a)] : k * 8'h11;
  endfunction

  // RAM wrapper: one-cycle read latency, stalled by rdy like the core.
  always @(posedge clk) begin
    if (rdy) mem_din <= rd(mem_a);
    if (mem_wr) begin
      ram[idx(mem_a)]   <= mem_dout;
      wflag[idx(mem_a)] <= 1'b1;
      wr_count          <= wr_count + 1;
    end
    if (if_done) if_pulses <= if_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_any_done(input int maxc, output int cyc, output logic gi, output logic gl);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(if_done || lsb_done) && cyc < maxc);
    gi = if_done;
    gl = lsb_done;
    chk("done_seen", {63'b0, gi | gl}, 64'd1);
  endtask

  initial begin
    int          cyc;
    logic        gi, gl;
    int unsigned wc0, ip0;
    logic        exp_lsb [4];
    int          exp_cyc [4];

    rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = 3'd0; lsb_addr = '0; lsb_wdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_lsb_done", lsb_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_lsb_rdata", lsb_rdata, 0);

    // Word load from 0x100
    rst = 1'b0;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd4; lsb_addr = 32'h100;
    tick(); chk("ld_a0", mem_a, 32'h100); chk("ld_done_early", lsb_done, 0);
    tick(); chk("ld_a1", mem_a, 32'h101);
    tick(); chk("ld_a2", mem_a, 32'h102);
    tick(); chk("ld_a3", mem_a, 32'h103);
    tick(); chk("ld_a3_hold", mem_a, 32'h103); chk("ld_done_c4", lsb_done, 0);
    tick(); chk("ld_done_c5", lsb_done, 1); chk("ld_rdata", lsb_rdata, 32'h44332211);
    lsb_req = 1'b0;
    tick(); chk("ld_done_pulse", lsb_done, 0);

    // Half-word store to 0x200
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd2; lsb_addr = 32'h200; lsb_wdata = 32'hDEADBEEF;
    wc0 = wr_count;
    tick(); chk("st_wr0", mem_wr, 1); chk("st_a0", mem_a, 32'h200); chk("st_d0", mem_dout, 8'hEF);
    tick(); chk("st_wr1", mem_wr, 1); chk("st_a1", mem_a, 32'h201); chk("st_d1", mem_dout, 8'hBE);
    tick(); chk("st_wr_off", mem_wr, 0); chk("st_done", lsb_done, 1);
    lsb_req = 1'b0;
    chk("st_ram200", rd(32'h200), 8'hEF);
    chk("st_ram201", rd(32'h201), 8'hBE);
    chk("st_ram202_untouched", wflag[idx(32'h202)], 0);
    chk("st_wr_count", wr_count - wc0, 2);

    // Arbitration: both requesting from reset, held throughout
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd1; lsb_addr = 32'h100;
    exp_lsb = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_cyc = '{3, 7, 4, 7};
    for (int i = 0; i < 4; i++) begin
      wait_any_done(20, cyc, gi, gl);
      chk($sformatf("arb_who%0d", i), {63'b0, gl}, {63'b0, exp_lsb[i]});
      chk($sformatf("arb_cyc%0d", i), cyc, exp_cyc[i]);
      if (i == 0) chk("arb_lsb_rdata", lsb_rdata, 32'h11);
      if (i == 1) chk("arb_if_data", if_data, 32'h44332211);
    end
    if_req = 1'b0; lsb_req = 1'b0;

    // Byte store into IO region with buffer full for the first cycles
    tick();
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd1; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
    wc0 = wr_count;
    tick(); chk("io_wr0", mem_wr, 0); chk("io_a", mem_a, 32'h30000); chk("io_d", mem_dout, 8'h41);
    tick(); chk("io_wr1", mem_wr, 0);
    tick(); chk("io_wr2", mem_wr, 0);
    io_buffer_full = 1'b0;
    #1 chk("io_resume", mem_wr, 1);
    tick(); chk("io_done", lsb_done, 1); chk("io_wr_off", mem_wr, 0);
    lsb_req = 1'b0;
    chk("io_ram", rd(32'h30000), 8'h41);
    chk("io_wr_count", wr_count - wc0, 1);

    // Fetch from 0x0 flushed at cnt == 2; LSB request ignored during flush
    tick();
    ip0 = if_pulses;
    if_req = 1'b1; if_addr = 32'h0;
    tick(); chk("rb_a0", mem_a, 32'h0);
    tick(); chk("rb_a1", mem_a, 32'h1);
    tick(); chk("rb_a2", mem_a, 32'h2);
    rollback_signal = 1'b1; if_req = 1'b0;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd1; lsb_addr = 32'h100;
    tick(); chk("rb_no_if_done", if_done, 0); chk("rb_a_hold", mem_a, 32'h2);
    tick(); chk("rb_no_grant", mem_a, 32'h2); chk("rb_no_lsb_done", lsb_done, 0);
    rollback_signal = 1'b0;
    tick(); chk("rb_grant_after", mem_a, 32'h100);
    tick();
    tick(); chk("rb_ld_done", lsb_done, 1); chk("rb_ld_rdata", lsb_rdata, 32'h11);
    lsb_req = 1'b0;
    chk("rb_if_pulses", if_pulses - ip0, 0);

    // Store continues through a rollback
    tick();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd4; lsb_addr = 32'h210; lsb_wdata = 32'h01020304;
    tick(); chk("sr_a0", mem_a, 32'h210); chk("sr_d0", mem_dout, 8'h04);
    tick(); chk("sr_a1", mem_a, 32'h211); chk("sr_d1", mem_dout, 8'h03);
    rollback_signal = 1'b1;
    tick(); chk("sr_a2", mem_a, 32'h212); chk("sr_wr2", mem_wr, 1);
    rollback_signal = 1'b0;
    tick(); chk("sr_a3", mem_a, 32'h213); chk("sr_d3", mem_dout, 8'h01);
    tick(); chk("sr_done", lsb_done, 1); chk("sr_wr_off", mem_wr, 0);
    lsb_req = 1'b0;
    chk("sr_ram", {rd(32'h213), rd(32'h212), rd(32'h211), rd(32'h210)}, 32'h01020304);

    // rdy low for 4 cycles in the middle of a word load
    tick();
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd4; lsb_addr = 32'h100;
    tick(); chk("rdy_a0", mem_a, 32'h100);
    tick(); chk("rdy_a1", mem_a, 32'h101);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rdy_frozen_a%0d", i), mem_a, 32'h101);
      chk($sformatf("rdy_frozen_done%0d", i), lsb_done, 0);
    end
    rdy = 1'b1;
    tick(); chk("rdy_a2", mem_a, 32'h102);
    tick(); chk("rdy_a3", mem_a, 32'h103);
    tick(); chk("rdy_not_done", lsb_done, 0);
    tick(); chk("rdy_done", lsb_done, 1); chk("rdy_rdata", lsb_rdata, 32'h44332211);
    lsb_req = 1'b0;

    // rdy gating of mem_wr, then asynchronous reset mid-store
    tick();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd4; lsb_addr = 32'h220; lsb_wdata = 32'hAABBCCDD;
    tick(); chk("ar_wr0", mem_wr, 1); chk("ar_d0", mem_dout, 8'hDD);
    rdy = 1'b0;
    #1 chk("ar_rdy_gate", mem_wr, 0);
    rdy = 1'b1;
    tick(); chk("ar_a1", mem_a, 32'h221); chk("ar_wr1", mem_wr, 1);
    #2 rst = 1'b1;
    #1 chk("ar_rst_wr", mem_wr, 0); chk("ar_rst_a", mem_a, 0); chk("ar_rst_d", mem_dout, 0);
    tick(); rst = 1'b0; lsb_req = 1'b0;
    tick(); chk("ar_no_done", lsb_done, 0); chk("ar_wr_idle", mem_wr, 0);
    chk("ar_ram220", rd(32'h220), 8'hDD);
    chk("ar_ram221_untouched", wflag[idx(32'h221)], 0);

    // Half-word load after reset: upper bytes of lsb_rdata cleared
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd2; lsb_addr = 32'h200;
    wait_any_done(10, cyc, gi, gl);
    chk("hl_lsb", {63'b0, gl}, 1);
    chk("hl_cyc", cyc, 4);
    chk("hl_rdata", lsb_rdata, 32'h0000BEEF);
    lsb_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
